syx_param_decoder: RTL and testbench

- Parses the incoming MIDI SysEx byte stream into single-parameter transactions: line select, address, data and read/write flag.
- Presents each transaction on the decoder side of the parameter address mux, which owns the parameter RAM bus for several cycles after each syx_data_ready pulse.
- Sits between the MIDI UART byte receiver and that mux; the mux is downstream.

---
 rtl/syx_param_decoder.sv | 183 ++++++++++++++++++
 tb/tb_syx_param_decoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/syx_param_decoder.sv
// MIDI SysEx parameter decoder: turns F0/ID/CMD/(SEL,ADDR,DATA)*/F7 streams into
// one-pulse parameter transactions. Define SYX_DATA8_EN for two-nibble 8-bit data.
module syx_param_decoder #(
    parameter int         addr_width = 7,
    parameter int         num_lines  = 7,
    parameter logic [6:0] MANUF_ID   = 7'h7D
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  byte_ready,
    input  logic [7:0]            midi_byte,
    output logic                  syx_data_ready,
    output logic                  dec_syx,
    output logic [addr_width-1:0] dec_addr,
    output logic [num_lines-1:0]  dec_sel_bus,
    output logic [7:0]            dec_data,
    output logic                  syx_active,
    output logic                  syx_err
);

    typedef enum logic [2:0] {
        IDLE, MANUF, CMD, SEL, ADDR, DATA, DATA_LO, SKIP
    } state_t;

    localparam logic [7:0] NUM_LINES_B = 8'(num_lines);

    state_t state, next_state;

    logic                  rd_q;
    logic [6:0]            sel_q;
    logic [addr_width-1:0] addr_q;
    logic                  bad_q;
    logic [num_lines-1:0]  sel_onehot;
    logic [7:0]            data_next;

    logic clear_err, set_err, load_cmd, load_sel, load_addr, commit;
    logic sel_bad;

    assign sel_bad = ({1'b0, midi_byte[6:0]} >= NUM_LINES_B);

`ifdef SYX_DATA8_EN
    logic [3:0] hi_q;
    logic       load_hi;
    logic       nibble_bad;
    assign nibble_bad = (midi_byte[6:4] != 3'b000);
    assign data_next  = {hi_q, midi_byte[3:0]};
`else
    assign data_next  = {1'b0, midi_byte[6:0]};
`endif

    always_comb begin
        sel_onehot = '0;
        for (int i = 0; i < num_lines; i++) begin
            sel_onehot[i] = (sel_q == 7'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Status bytes override the parse state; real-time bytes (F8-FF) are transparent.
    always_comb begin
        next_state = state;
        clear_err  = 1'b0;
        set_err    = 1'b0;
        load_cmd   = 1'b0;
        load_sel   = 1'b0;
        load_addr  = 1'b0;
        commit     = 1'b0;
`ifdef SYX_DATA8_EN
        load_hi    = 1'b0;
`endif
        if (byte_ready) begin
            if (midi_byte[7]) begin
                if (midi_byte[7:3] == 5'b11111) begin
                    next_state = state;
                end else if (midi_byte == 8'hF0) begin
                    next_state = MANUF;
                    clear_err  = 1'b1;
                end else begin
                    next_state = IDLE;
                end
            end else begin
                case (state)
                    MANUF: next_state = (midi_byte[6:0] == MANUF_ID) ? CMD : SKIP;
                    CMD: begin
                        if (midi_byte[6:1] == 6'd0) begin
                            load_cmd   = 1'b1;
                            next_state = SEL;
                        end else begin
                            next_state = SKIP;
                        end
                    end
                    SEL: begin
                        load_sel   = 1'b1;
                        set_err    = sel_bad;
                        next_state = ADDR;
                    end
                    ADDR: begin
                        load_addr  = 1'b1;
                        next_state = DATA;
                    end
`ifdef SYX_DATA8_EN
                    DATA: begin
                        load_hi    = 1'b1;
                        set_err    = nibble_bad;
                        next_state = DATA_LO;
                    end
                    DATA_LO: begin
                        set_err    = nibble_bad;
                        commit     = !bad_q && !nibble_bad;
                        next_state = SEL;
                    end
`else
                    DATA: begin
                        commit     = !bad_q;
                        next_state = SEL;
                    end
`endif
                    default: next_state = state;
                endcase
            end
        end
    end

    // A bad triple still walks SEL/ADDR/DATA so the following triple stays aligned.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_q           <= 1'b0;
            sel_q          <= '0;
            addr_q         <= '0;
            bad_q          <= 1'b0;
            syx_data_ready <= 1'b0;
            dec_syx        <= 1'b0;
            dec_addr       <= '0;
            dec_sel_bus    <= '0;
            dec_data       <= '0;
            syx_err        <= 1'b0;
`ifdef SYX_DATA8_EN
            hi_q           <= '0;
`endif
        end else begin
            syx_data_ready <= commit;
            if (clear_err) begin
                syx_err <= 1'b0;
            end else if (set_err) begin
                syx_err <= 1'b1;
            end
            if (load_cmd) begin
                rd_q <= midi_byte[0];
            end
            if (load_sel) begin
                sel_q <= midi_byte[6:0];
                bad_q <= sel_bad;
            end
            if (load_addr) begin
                addr_q <= midi_byte[addr_width-1:0];
            end
`ifdef SYX_DATA8_EN
            if (load_hi) begin
                hi_q <= midi_byte[3:0];
                if (nibble_bad) begin
                    bad_q <= 1'b1;
                end
            end
`endif
            if (commit) begin
                dec_syx     <= rd_q;
                dec_addr    <= addr_q;
                dec_sel_bus <= sel_onehot;
                dec_data    <= data_next;
            end
        end
    end

    assign syx_active = (state != IDLE);

endmodule

// File: tb/tb_syx_param_decoder.sv
// Scoreboard bench for syx_param_decoder: directed SysEx streams push expected
// transactions; a negedge monitor pops and compares on every syx_data_ready pulse.
module tb_syx_param_decoder;

    logic       clk = 1'b0;
    logic       reset;
    logic       byte_ready;
    logic [7:0] midi_byte;
    logic       syx_data_ready;
    logic       dec_syx;
    logic [6:0] dec_addr;
    logic [6:0] dec_sel_bus;
    logic [7:0] dec_data;
    logic       syx_active;
    logic       syx_err;

    syx_param_decoder #(.addr_width(7), .num_lines(7), .MANUF_ID(7'h7D)) dut (
        .clk(clk), .reset(reset), .byte_ready(byte_ready), .midi_byte(midi_byte),
        .syx_data_ready(syx_data_ready), .dec_syx(dec_syx), .dec_addr(dec_addr),
        .dec_sel_bus(dec_sel_bus), .dec_data(dec_data), .syx_active(syx_active),
        .syx_err(syx_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] sel;
        logic [6:0] addr;
        logic [7:0] data;
        logic       syx;
        int         due;
    } exp_t;

    exp_t exp_q[$];
    exp_t exp_next;
    exp_t mon_e;
    bit   exp_pending = 1'b0;
    int   vectors     = 0;
    int   miscompares = 0;
    int   cyc         = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        vectors++;
        if (actual !== required) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, required);
        end
    endtask

    // Expectation is armed here and stamped with its due cycle by the next applyStimulus.
    task automatic expectTxn(input logic [6:0] sel, input logic [6:0] addr, input logic [7:0] data, input logic syx);
        exp_next    = '{sel: sel, addr: addr, data: data, syx: syx, due: 0};
        exp_pending = 1'b1;
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        @(negedge clk);
        byte_ready = 1'b1;
        midi_byte  = b;
        if (exp_pending) begin
            exp_next.due = cyc + 1;
            exp_q.push_back(exp_next);
            exp_pending = 1'b0;
        end
        @(negedge clk);
        byte_ready = 1'b0;
        repeat (6) @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (syx_data_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("[TB] FAIL unexpected_pulse: got pulse at cycle %0d, expected none", cyc);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("pulse_cycle", 32'(cyc), 32'(mon_e.due));
                checkOutput("dec_sel_bus", 32'(dec_sel_bus), 32'(mon_e.sel));
                checkOutput("dec_addr", 32'(dec_addr), 32'(mon_e.addr));
                checkOutput("dec_data", 32'(dec_data), 32'(mon_e.data));
                checkOutput("dec_syx", 32'(dec_syx), 32'(mon_e.syx));
            end
        end
    end

    initial begin
        reset      = 1'b1;
        byte_ready = 1'b0;
        midi_byte  = 8'h00;
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(syx_data_ready), 32'h0);
        checkOutput("rst_sel_bus", 32'(dec_sel_bus), 32'h0);
        checkOutput("rst_addr", 32'(dec_addr), 32'h0);
        checkOutput("rst_data", 32'(dec_data), 32'h0);
        checkOutput("rst_active", 32'(syx_active), 32'h0);
        checkOutput("rst_err", 32'(syx_err), 32'h0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

`ifdef SYX_DATA8_EN
        applyStimulus(8'hF0); applyStimulus(8'h7D); applyStimulus(8'h00);
        applyStimulus(8'h01); applyStimulus(8'h22); applyStimulus(8'h0A);
        expectTxn(7'b0000010, 7'h22, 8'hAB, 1'b0);
        applyStimulus(8'h0B);
        checkOutput("d8_err_clean", 32'(syx_err), 32'h0);
        applyStimulus(8'hF7);
        applyStimulus(8'hF0); applyStimulus(8'h7D); applyStimulus(8'h00);
        applyStimulus(8'h01); applyStimulus(8'h22); applyStimulus(8'h0A);
        applyStimulus(8'h1B);
        checkOutput("d8_err_set", 32'(syx_err), 32'h1);
        checkOutput("d8_held_data", 32'(dec_data), 32'hAB);
        applyStimulus(8'hF7);
`else
        // Single write triple
        applyStimulus(8'hF0);
        checkOutput("active_after_f0", 32'(syx_active), 32'h1);
        applyStimulus(8'h7D); applyStimulus(8'h00); applyStimulus(8'h02); applyStimulus(8'h15);
        expectTxn(7'b0000100, 7'h15, 8'h3A, 1'b0);
        applyStimulus(8'h3A);
        checkOutput("write_err", 32'(syx_err), 32'h0);
        checkOutput("write_active", 32'(syx_active), 32'h1);
        applyStimulus(8'hF7);
        checkOutput("active_after_f7", 32'(syx_active), 32'h0);
        checkOutput("held_after_f7", 32'(dec_addr), 32'h15);

        // Two read triples with an interleaved F8 and the top select line
        applyStimulus(8'hF0); applyStimulus(8'h7D); applyStimulus(8'h01);
        applyStimulus(8'h00); applyStimulus(8'h01);
        expectTxn(7'b0000001, 7'h01, 8'h00, 1'b1);
        applyStimulus(8'h00);
        applyStimulus(8'hF8);
        applyStimulus(8'h06); applyStimulus(8'h7F);
        expectTxn(7'b1000000, 7'h7F, 8'h00, 1'b1);
        applyStimulus(8'h00);
        applyStimulus(8'hF7);

        // Select index equal to num_lines
        applyStimulus(8'hF0); applyStimulus(8'h7D); applyStimulus(8'h00);
        applyStimulus(8'h07);
        checkOutput("badsel_err", 32'(syx_err), 32'h1);
        applyStimulus(8'h10); applyStimulus(8'h55); applyStimulus(8'hF7);
        checkOutput("badsel_err_sticky", 32'(syx_err), 32'h1);
        checkOutput("badsel_held_sel", 32'(dec_sel_bus), 32'h40);
        checkOutput("badsel_held_addr", 32'(dec_addr), 32'h7F);
        checkOutput("badsel_held_syx", 32'(dec_syx), 32'h1);
        applyStimulus(8'hF0);
        checkOutput("f0_clears_err", 32'(syx_err), 32'h0);
        applyStimulus(8'hF7);

        // Wrong manufacturer, then abort by a non-F7 status byte
        applyStimulus(8'hF0); applyStimulus(8'h41); applyStimulus(8'h00);
        applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h03);
        checkOutput("skip_active", 32'(syx_active), 32'h1);
        applyStimulus(8'hF7);
        checkOutput("skip_ended", 32'(syx_active), 32'h0);
        applyStimulus(8'hF0); applyStimulus(8'h7D); applyStimulus(8'h00);
        applyStimulus(8'h01); applyStimulus(8'h02); applyStimulus(8'h90);
        checkOutput("abort_idle", 32'(syx_active), 32'h0);

        // Asynchronous reset in the middle of a message
        applyStimulus(8'hF0); applyStimulus(8'h7D); applyStimulus(8'h00); applyStimulus(8'h03);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async_sel_bus", 32'(dec_sel_bus), 32'h0);
        checkOutput("async_addr", 32'(dec_addr), 32'h0);
        checkOutput("async_syx", 32'(dec_syx), 32'h0);
        checkOutput("async_active", 32'(syx_active), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        applyStimulus(8'h04); applyStimulus(8'h05);
        checkOutput("post_reset_idle", 32'(syx_active), 32'h0);
        checkOutput("post_reset_data", 32'(dec_data), 32'h0);
`endif

        repeat (4) @(negedge clk);
        checkOutput("pending_expected", 32'(exp_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
